// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed scan controller for a common-anode seven-segment display.
// Holds a shift buffer of digit codes fed through a valid/ready push port.
// The newest digit is shown in the rightmost position.
// Cycles active-low digit enables with a blanking gap between digits to suppress ghosting.
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [3:0]            push_code,
    output logic                  push_ready,
    input  logic                  clear,
    output logic [3:0]            count,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic [7:0]            seg_out
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       CNT_FULL   = 4'(NUM_DIGITS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_seg;
    logic [3:0]            r_buf [NUM_DIGITS];
    logic [3:0]            r_count;

    logic                  w_push;
    logic [NUM_DIGITS-1:0] w_an_sel;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    assign push_ready = !rst && !clear;
    assign w_push     = push_valid && push_ready;
    assign w_an_sel   = ~(NUM_DIGITS'(1) << r_idx);

    assign count   = r_count;
    assign an_out  = r_an;
    assign seg_out = r_seg;

    // Digit buffer: clear has priority over a push; a push shifts older digits left.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_buf[k] <= 4'hF;
            end
            r_count <= 4'd0;
        end else if (w_push) begin
            r_buf[0] <= push_code;
            for (int k = 1; k < NUM_DIGITS; k++) begin
                r_buf[k] <= r_buf[k-1];
            end
            if (r_count != CNT_FULL) begin
                r_count <= r_count + 4'd1;
            end
        end
    end

    // Scanner FSM with registered digit enables and segments, independent of buffer traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_an    <= '1;
            r_seg   <= 8'hFF;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                end
            endcase

            if (r_state == ST_SHOW) begin
                r_an  <= w_an_sel;
                r_seg <= seg_decode(r_buf[r_idx]);
            end else begin
                r_an  <= '1;
                r_seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl (4 digits, SCAN_DIV=4, BLANK_CYC=2).
module tb_display_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       push_valid;
    logic [3:0] push_code;
    logic       push_ready;
    logic       clear;
    logic [3:0] count;
    logic [3:0] an_out;
    logic [7:0] seg_out;

    display_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_valid(push_valid),
        .push_code (push_code),
        .push_ready(push_ready),
        .clear     (clear),
        .count     (count),
        .an_out    (an_out),
        .seg_out   (seg_out)
    );

    typedef struct {
        int         cyc;
        bit         m_an;
        bit         m_seg;
        bit         m_cnt;
        bit         m_rdy;
        logic [3:0] an;
        logic [7:0] seg;
        logic [3:0] cnt;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   R = 0;
    logic [3:0] eb [4];
    logic [3:0] ecnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter shared by stimulus and monitor.
    always @(posedge clk) cyc <= cyc + 1;

    // Datasheet segment table, written out independently of the design.
    function automatic logic [7:0] dec(input logic [3:0] c);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        return tbl[c];
    endfunction

    task automatic add(input int c, input bit ma, input bit ms, input bit mc, input bit mr,
                       input logic [3:0] an, input logic [7:0] seg, input logic [3:0] cnt,
                       input logic rdy, input string nm);
        exp_t e;
        e.cyc = c; e.m_an = ma; e.m_seg = ms; e.m_cnt = mc; e.m_rdy = mr;
        e.an = an; e.seg = seg; e.cnt = cnt; e.rdy = rdy; e.name = nm;
        q.push_back(e);
    endtask

    // Expected display for the next n edges; edge R+k shows the state held after edge R+k-1,
    // which repeats every 6 edges: 2 blank, then 4 lit for digit (j/6)%4.
    task automatic expect_scan(input int n, input string nm);
        for (int i = 1; i <= n; i++) begin
            int c, j, d;
            logic [3:0] a;
            logic [7:0] s;
            c = cyc + i;
            j = c - R - 1;
            if (j < 0 || (j % 6) < 2) begin
                a = 4'hF;
                s = 8'hFF;
            end else begin
                d = (j / 6) % 4;
                a = ~(4'b0001 << d);
                s = dec(eb[d]);
            end
            add(c, 1, 1, 1, 0, a, s, ecnt, 1'b0, nm);
        end
    endtask

    task automatic do_push(input logic [3:0] code, input logic [3:0] cnt_after);
        push_valid = 1'b1;
        push_code  = code;
        add(cyc, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0, 1'b1, "push_ready_high");
        @(posedge clk); #1;
        push_valid = 1'b0;
        add(cyc, 0, 0, 1, 0, 4'h0, 8'h00, cnt_after, 1'b0, "count_after_push");
    endtask

    task automatic chk(input string nm, input int c, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
        end
    endtask

    // Monitor: pops every expectation due at this edge and compares it to the sampled outputs.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.m_an)  chk({e.name, ".an_out"},     e.cyc, {4'h0, an_out}, {4'h0, e.an});
            if (e.m_seg) chk({e.name, ".seg_out"},    e.cyc, seg_out, e.seg);
            if (e.m_cnt) chk({e.name, ".count"},      e.cyc, {4'h0, count}, {4'h0, e.cnt});
            if (e.m_rdy) chk({e.name, ".push_ready"}, e.cyc, {7'h0, push_ready}, {7'h0, e.rdy});
        end
    end

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_code = 4'h0; clear = 1'b0;
        eb = '{4'hF, 4'hF, 4'hF, 4'hF};
        ecnt = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        add(cyc, 1, 1, 1, 1, 4'hF, 8'hFF, 4'd0, 1'b0, "reset");
        R = cyc;
        @(negedge clk); #1;
        rst = 1'b0;

        // Idle scan: all blank digits, count 0
        expect_scan(24, "idle_scan");
        repeat (24) @(posedge clk);
        #1;

        // Push 3 then 7
        do_push(4'h3, 4'd1);
        do_push(4'h7, 4'd2);
        eb = '{4'h7, 4'h3, 4'hF, 4'hF};
        ecnt = 4'd2;
        expect_scan(24, "two_digits");
        repeat (24) @(posedge clk);
        #1;

        // Five consecutive pushes, count saturates at 4
        do_push(4'h1, 4'd3);
        do_push(4'h2, 4'd4);
        do_push(4'h3, 4'd4);
        do_push(4'h4, 4'd4);
        do_push(4'h5, 4'd4);
        eb = '{4'h5, 4'h4, 4'h3, 4'h2};
        ecnt = 4'd4;
        expect_scan(24, "full_buffer");
        repeat (24) @(posedge clk);
        #1;

        // Clear held together with a push of 9: clear wins
        clear = 1'b1; push_valid = 1'b1; push_code = 4'h9;
        add(cyc, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0, 1'b0, "ready_low_in_clear");
        @(posedge clk); #1;
        add(cyc, 0, 0, 1, 1, 4'h0, 8'h00, 4'd0, 1'b0, "clear_count");
        @(posedge clk); #1;
        clear = 1'b0; push_valid = 1'b0;
        eb = '{4'hF, 4'hF, 4'hF, 4'hF};
        ecnt = 4'd0;
        expect_scan(24, "after_clear");
        repeat (24) @(posedge clk);
        #1;

        // Non-decimal code shows blank but still counts
        do_push(4'h8, 4'd1);
        do_push(4'hC, 4'd2);
        eb = '{4'hC, 4'h8, 4'hF, 4'hF};
        ecnt = 4'd2;
        expect_scan(24, "code_C_blank");
        repeat (24) @(posedge clk);
        #1;

        // Reset in the middle of a SHOW phase with a push pending
        while (((cyc - R) % 6) != 3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; push_valid = 1'b1; push_code = 4'h5;
        @(posedge clk); #1;
        add(cyc, 1, 1, 1, 1, 4'hF, 8'hFF, 4'd0, 1'b0, "mid_show_reset");
        R = cyc;
        @(negedge clk); #1;
        rst = 1'b0; push_valid = 1'b0;
        eb = '{4'hF, 4'hF, 4'hF, 4'hF};
        ecnt = 4'd0;
        expect_scan(12, "restart_scan");
        repeat (12) @(posedge clk);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
